// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a parallel pattern over valid/ready and shifts it out MSB-first, optionally repeated.
// Optional build macro SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit after every repetition.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 3,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  input  logic             en,
  output logic             out,
  output logic             bit_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx_r;
  logic [REP_W-1:0] rep_r;
  logic             out_r;
  logic             bit_valid_r;
  logic             done_r;
  logic             load_ready_r;
  logic [LEN_W-1:0] len_s;
  logic             last_s;

  // Bit select by a LEN_W-wide index, safe for any WIDTH <= 2**LEN_W
  function automatic logic bit_at(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_W'(i) == idx) b = d[i];
    end
    return b;
  endfunction

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic par_phase_r;

  // Even parity over bits [n:0] of the pattern
  function automatic logic parity_of(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_W'(i) <= n) p = p ^ d[i];
    end
    return p;
  endfunction
`endif

  // Clamp the requested length to the pattern register and flag the final pattern bit
  always_comb begin
    len_s  = load_len;
    last_s = 1'b0;
    if (load_len > LEN_MAX) begin
      len_s = LEN_MAX;
    end else begin
      len_s = load_len;
    end
    if (idx_r == {LEN_W{1'b0}}) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Transmit FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      data_r       <= {WIDTH{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      idx_r        <= {LEN_W{1'b0}};
      rep_r        <= {REP_W{1'b0}};
      out_r        <= 1'b0;
      bit_valid_r  <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_phase_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (load_valid) begin
            data_r       <= load_data;
            len_r        <= len_s;
            idx_r        <= len_s;
            rep_r        <= load_rep;
            out_r        <= bit_at(load_data, len_s);
            bit_valid_r  <= 1'b1;
            load_ready_r <= 1'b0;
            state_r      <= SHIFT;
          end else begin
            out_r        <= 1'b0;
            bit_valid_r  <= 1'b0;
            load_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            if (!last_s) begin
              idx_r <= idx_r - 1'b1;
              out_r <= bit_at(data_r, idx_r - 1'b1);
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            else if (!par_phase_r) begin
              par_phase_r <= 1'b1;
              out_r       <= parity_of(data_r, len_r);
            end
`endif
            else if (rep_r != {REP_W{1'b0}}) begin
              // Restart the pattern on the very next bit slot, no gap
              rep_r <= rep_r - 1'b1;
              idx_r <= len_r;
              out_r <= bit_at(data_r, len_r);
`ifdef SEQ_PATTERN_TX_PARITY_EN
              par_phase_r <= 1'b0;
`endif
            end else begin
              out_r       <= 1'b0;
              bit_valid_r <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= DONE;
`ifdef SEQ_PATTERN_TX_PARITY_EN
              par_phase_r <= 1'b0;
`endif
            end
          end
        end
        DONE: begin
          done_r       <= 1'b0;
          load_ready_r <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          out_r        <= 1'b0;
          bit_valid_r  <= 1'b0;
          done_r       <= 1'b0;
          load_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign out        = out_r;
  assign bit_valid  = bit_valid_r;
  assign done       = done_r;
  assign load_ready = load_ready_r;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter. It is the stimulus end of the single-bit `in` stream that our sequence-detector FSMs consume. A parallel pattern is loaded over a valid/ready handshake and shifted out MSB-first, one bit per enabled clock. The pattern can be repeated back-to-back with no gap, so overlapping-sequence detection can be exercised. The block sits upstream of the detector and drives its `in` port directly.

Parameters:
WIDTH, 8, maximum pattern length in bits.
LEN_W, 3, width of load_len; WIDTH <= 2**LEN_W required.
REP_W, 4, width of load_rep (repeat count).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  pattern load request.
load_ready  output  1  block can accept a pattern.
load_data  input  WIDTH  pattern; bit (len-1) is sent first.
load_len  input  LEN_W  pattern length minus 1; length = load_len+1.
load_rep  input  REP_W  extra repetitions; total transmissions = load_rep+1.
en  input  1  bit-advance enable (pacing); when low, the current bit is held.
out  output  1  serial bit, registered; feeds detector `in`.
bit_valid  output  1  high while out carries a pattern bit.
done  output  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset (sync, active-high): state=IDLE; out=0, bit_valid=0, done=0; internal shift/len/rep registers cleared. Reset mid-transfer aborts the transfer immediately at that edge; no done pulse is generated.
- Length rule: len = load_len+1. If len > WIDTH, len is clamped to WIDTH.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1; out=0; bit_valid=0.
  - On an edge with load_valid=1: capture data, len and rep; set out <= load_data[len-1] and bit_valid <= 1; go to SHIFT.
  - Latency: the first bit is visible the cycle after acceptance. en is not required for the accept edge.
- SHIFT:
  - load_ready=0; load_valid is ignored.
  - Edge with en=0: all registers hold; out and bit_valid are unchanged.
  - Edge with en=1, not the last bit: out <= next lower bit.
  - Edge with en=1, last bit (bit 0), rep_remaining>0: decrement rep_remaining; out <= data[len-1]. This restarts the pattern with no gap cycle.
  - Edge with en=1, last bit, rep_remaining=0: out <= 0, bit_valid <= 0, done <= 1; go to DONE.
- DONE: done is high for exactly one cycle; load_ready=0; next edge goes to IDLE with done <= 0. A new load is accepted on the IDLE cycle that follows, so the minimum spacing between patterns is 2 idle cycles of out=0.
- Bit counter width is LEN_W. The repeat counter wraps never, because it only decrements while nonzero.
- Total bit_valid cycles with en held high = len*(load_rep+1).

Optional Feature:
SEQ_PATTERN_TX_PARITY_EN:
- Defined: after bit 0 of every repetition, one extra bit equal to the even parity (XOR) of the len transmitted bits is sent. It is subject to en and has bit_valid=1. The next repetition or the DONE state follows it, and the total bit count becomes (len+1)*(load_rep+1).
- Undefined: no parity bit is sent, and the parity logic is absent.

Test Plan:
- Basic: load_data=8'b0000_1010, load_len=3, load_rep=0, en=1 -> out=1,0,1,0 on the 4 cycles after accept; bit_valid high for exactly 4 cycles; done pulses on cycle 5; load_ready returns on cycle 6.
- Repeat/overlap: load_data=3'b101, load_len=2, load_rep=2 -> out=101101101 back-to-back (9 cycles, no gap); exactly one done pulse.
- Pacing: basic load with en toggling 1,0,0,1,1,1 -> each bit held across the en=0 cycles; sequence still 1,0,1,0; done follows the 4th advance.
- Clamp/handshake: load_len=7 with WIDTH=8 sends all 8 bits; with WIDTH=4, LEN_W=3 and load_len=7 -> 4 bits sent; load_valid pulsed mid-SHIFT -> ignored, load_ready=0.
- Reset mid-operation: assert reset for one cycle after the 2nd bit -> next cycle out=0, bit_valid=0, done never pulses, load_ready=1.
- Parity (macro defined): load_data=4'b1011, load_len=3, load_rep=1 -> out=1,0,1,1,1,1,0,1,1,1 (10 bits); done on cycle 11.
